// File: rtl/ws2812_ctrl_if.sv
// Host-side handshake bundle for the WS2812 frame controller.
// Ports: ws2812_start, cfg_data (host->ctrl); cfg_start, busy, frame_done (ctrl->host).
interface ws2812_ctrl_if;
   logic        ws2812_start;
   logic [23:0] cfg_data;
   logic        cfg_start;
   logic        busy;
   logic        frame_done;

   modport master (
      output ws2812_start, cfg_data,
      input  cfg_start, busy, frame_done
   );

   modport slave (
      input  ws2812_start, cfg_data,
      output cfg_start, busy, frame_done
   );
endinterface

// File: rtl/ws2812_ctrl.sv
// WS2812 LED chain driver: streams PIXELS 24-bit words, then a low latch gap.
// Ports: sys_clk, sys_rst_n (async low), bus (slave handshake), dout (serial line).
module ws2812_ctrl #(
   parameter int PIXELS       = 64,
   parameter int BIT_PERIOD   = 63,
   parameter int T0H          = 20,
   parameter int T1H          = 40,
   parameter int RESET_CYCLES = 15000
) (
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   ws2812_ctrl_if.slave bus,
   output logic         dout
);

   localparam int CMAX = (BIT_PERIOD > RESET_CYCLES) ? BIT_PERIOD : RESET_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int PW   = (PIXELS > 1) ? $clog2(PIXELS) : 1;

   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] pix_t;

   localparam cnt_t BP_LAST  = cnt_t'(BIT_PERIOD - 1);
   localparam cnt_t RC_LAST  = cnt_t'(RESET_CYCLES - 1);
   localparam cnt_t T0       = cnt_t'(T0H);
   localparam cnt_t T1       = cnt_t'(T1H);
   localparam pix_t PIX_LAST = pix_t'(PIXELS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

   state_t      state, state_n;
   cnt_t        cyc, cyc_n;
   logic [4:0]  bit_cnt, bit_n;
   pix_t        pix, pix_n;
   logic [23:0] sh, sh_n;
   logic        pend, pend_n;
   logic        dout_n;
   cnt_t        hi;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= IDLE;
         cyc     <= '0;
         bit_cnt <= '0;
         pix     <= '0;
         sh      <= '0;
         pend    <= 1'b0;
         dout    <= 1'b0;
      end else begin
         state   <= state_n;
         cyc     <= cyc_n;
         bit_cnt <= bit_n;
         pix     <= pix_n;
         sh      <= sh_n;
         pend    <= pend_n;
         dout    <= dout_n;
      end
   end

   // cyc counts cycles within a bit in SEND and the gap length in LATCH.
   always_comb begin
      state_n = state;
      cyc_n   = cyc;
      bit_n   = bit_cnt;
      pix_n   = pix;
      sh_n    = sh;
      pend_n  = pend;
      if (bus.ws2812_start && state != IDLE)
         pend_n = 1'b1;
      unique case (state)
         IDLE: begin
            if (bus.ws2812_start || pend) begin
               state_n = LOAD;
               pend_n  = 1'b0;
            end
         end
         LOAD: begin
            sh_n    = bus.cfg_data;
            bit_n   = '0;
            cyc_n   = '0;
            state_n = SEND;
         end
         SEND: begin
            if (cyc == BP_LAST) begin
               cyc_n = '0;
               sh_n  = {sh[22:0], 1'b0};
               if (bit_cnt == 5'd23) begin
                  bit_n = '0;
                  if (pix == PIX_LAST) begin
                     pix_n   = '0;
                     state_n = LATCH;
                  end else begin
                     pix_n   = pix + 1'b1;
                     state_n = LOAD;
                  end
               end else begin
                  bit_n = bit_cnt + 1'b1;
               end
            end else begin
               cyc_n = cyc + 1'b1;
            end
         end
         LATCH: begin
            if (cyc == RC_LAST) begin
               cyc_n   = '0;
               state_n = IDLE;
            end else begin
               cyc_n = cyc + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      // dout is registered, so it is computed from next-cycle state.
      hi     = sh_n[23] ? T1 : T0;
      dout_n = (state_n == SEND) && (cyc_n < hi);
   end

   assign bus.cfg_start  = (state == LOAD);
   assign bus.busy       = (state != IDLE);
   assign bus.frame_done = (state == LATCH) && (cyc == RC_LAST);

endmodule

// File: tb/tb_ws2812_ctrl.sv
// Randomized bench for ws2812_ctrl against a timeline-based frame model.
// Ports: none (drives the DUT through a ws2812_ctrl_if instance).
module tb_ws2812_ctrl;
   localparam int PIXELS = 4;
   localparam int BP     = 10;
   localparam int T0H    = 3;
   localparam int T1H    = 7;
   localparam int RC     = 50;
   localparam int PP     = 1 + 24 * BP;
   localparam int FL     = PIXELS * PP + RC;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dout;

   ws2812_ctrl_if bus_if();

   ws2812_ctrl #(
      .PIXELS(PIXELS), .BIT_PERIOD(BP), .T0H(T0H),
      .T1H(T1H), .RESET_CYCLES(RC)
   ) dut (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .bus(bus_if), .dout(dout)
   );

   always #5 clk = ~clk;

   int nvec = 0, nerr = 0;
   int n_load = 0, n_done = 0;
   int cyc = 0, t_first = 0, t_len = 0;
   bit seen = 0;
   bit rnd_cfg = 0;
   int l0, d0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: a frame is a timeline t = 0..FL-1 starting at the first LOAD.
   bit          m_act, m_pend;
   int          m_t;
   logic [23:0] m_word;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act <= 0; m_pend <= 0; m_t <= 0; m_word <= '0;
      end else if (m_act) begin
         if (bus_if.ws2812_start) m_pend <= 1;
         if (m_t < PIXELS * PP && m_t % PP == 0) m_word <= bus_if.cfg_data;
         if (m_t == FL - 1) m_act <= 0;
         else m_t <= m_t + 1;
      end else if (bus_if.ws2812_start || m_pend) begin
         m_act <= 1; m_t <= 0; m_pend <= 0;
      end
   end

   function automatic logic [3:0] exp_out(input bit act, input int t,
                                          input logic [23:0] w);
      int r, b, c, hi;
      if (!act) return 4'b0000;
      if (t >= PIXELS * PP) return {3'b001, t == FL - 1};
      r = t % PP;
      if (r == 0) return 4'b0110;
      b = (r - 1) / BP;
      c = (r - 1) % BP;
      hi = w[23-b] ? T1H : T0H;
      return {c < hi, 3'b010};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      check("out", {28'd0, dout, bus_if.cfg_start, bus_if.busy, bus_if.frame_done},
            {28'd0, exp_out(m_act, m_t, m_word)});
      if (bus_if.cfg_start) n_load++;
      if (bus_if.frame_done) n_done++;
      if (!rst_n) seen = 0;
      else if (bus_if.cfg_start && !seen) begin
         t_first = cyc; seen = 1;
      end
      if (bus_if.frame_done) begin
         t_len = cyc - t_first + 1; seen = 0;
      end
   end

   task automatic step(input logic st);
      @(posedge clk); #1;
      if (rnd_cfg) bus_if.cfg_data = 24'($urandom);
      bus_if.ws2812_start = st;
   endtask

   task automatic wait_idle(input string tag);
      int quiet = 0, n = 0;
      while (quiet < 3 && n < 4 * FL) begin
         step(1'b0); n++;
         quiet = bus_if.busy ? 0 : quiet + 1;
      end
      check(tag, 32'(n < 4 * FL), 32'd1);
   endtask

   task automatic wait_loads(input int target, input string tag);
      int n = 0;
      while (n_load < target && n < 2 * FL) begin
         step(1'b0); n++;
      end
      check(tag, 32'(n_load >= target), 32'd1);
   endtask

   task automatic one_frame(input string tag, input logic [23:0] w, input bit rnd);
      rnd_cfg = rnd;
      bus_if.cfg_data = w;
      l0 = n_load; d0 = n_done;
      step(1'b1);
      step(1'b0);
      check({tag, "_lat_load"}, 32'(bus_if.cfg_start), 32'd1);
      step(1'b0);
      check({tag, "_lat_rise"}, 32'(dout), 32'd1);
      wait_idle({tag, "_to"});
      check({tag, "_loads"}, n_load - l0, PIXELS);
      check({tag, "_frames"}, n_done - d0, 1);
      check({tag, "_len"}, t_len, FL);
   endtask

   initial begin
      bus_if.ws2812_start = 1'b0;
      bus_if.cfg_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", {28'd0, dout, bus_if.cfg_start, bus_if.busy, bus_if.frame_done}, 32'd0);
      rst_n = 1'b1;
      step(1'b0); step(1'b0);
      check("idle_busy", 32'(bus_if.busy), 32'd0);

      one_frame("ff", 24'hFF0000, 0);
      one_frame("a5", 24'hA5A5A5, 0);
      one_frame("rnd", 24'h123456, 1);

      // restart requested during the last pixel
      rnd_cfg = 1;
      l0 = n_load; d0 = n_done;
      step(1'b1);
      wait_loads(l0 + PIXELS, "s4_wl");
      repeat (30) step(1'b0);
      step(1'b1);
      wait_idle("s4_to");
      check("s4_frames", n_done - d0, 2);
      check("s4_loads", n_load - l0, 2 * PIXELS);

      // three requests collapse into one restart
      l0 = n_load; d0 = n_done;
      step(1'b1);
      repeat (100) step(1'b0);
      step(1'b1);
      repeat (300) step(1'b0);
      step(1'b1);
      repeat (200) step(1'b0);
      step(1'b1);
      wait_idle("s5_to");
      check("s5_frames", n_done - d0, 2);
      check("s5_loads", n_load - l0, 2 * PIXELS);

      // reset in the middle of pixel 2
      l0 = n_load;
      step(1'b1);
      wait_loads(l0 + 3, "s6_wl");
      repeat (50) step(1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_busy", 32'(bus_if.busy), 32'd0);
      step(1'b0); step(1'b0);
      rst_n = 1'b1;
      l0 = n_load;
      repeat (200) step(1'b0);
      check("rst_noload", n_load - l0, 0);
      check("rst_idle", 32'(bus_if.busy), 32'd0);

      // random request storm with random pixel data
      for (int i = 0; i < 3000; i++)
         step(1'($urandom_range(0, 149) == 0));
      wait_idle("s7_to");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
